thunder_tim_parser: RTL

//  Consumes the byte stream from the Thunderbolt UART receiver (i_thunder_rx path) and extracts
//  the timing packet (ID 0x8F, subcode 0xAB). Latches seconds/minutes/hour/day/month/year

---
 rtl/thunder_tim_parser.sv | 138 +++++++++++++
 1 files changed

// File: rtl/thunder_tim_parser.sv
// Thunderbolt timing-packet parser (ID 0x8F / subcode 0xAB).
// Ports: i_clk_10/i_rst, i_rx_dv/i_rx_byte in; time fields, o_time_valid, o_timeout_err, o_pkt_count out.
module thunder_tim_parser #(
  parameter logic [7:0] TIM_ID       = 8'h8F,
  parameter logic [7:0] TIM_SUBCODE  = 8'hAB,
  parameter int         SKIP_BYTES   = 9,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic        i_clk_10,
  input  logic        i_rst,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic [7:0]  o_seconds,
  output logic [7:0]  o_minutes,
  output logic [7:0]  o_hour,
  output logic [7:0]  o_day,
  output logic [7:0]  o_month,
  output logic [15:0] o_year,
  output logic        o_time_valid,
  output logic        o_timeout_err,
  output logic [7:0]  o_pkt_count
);

  // byte counter also indexes the 7 capture bytes, so keep at least 3 bits
  localparam int CW0 = $clog2(SKIP_BYTES + 1);
  localparam int BW  = (CW0 > 3) ? CW0 : 3;
  localparam int TW  = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUB,
    S_SKIP,
    S_CAP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [BW-1:0]   r_cnt;
  logic [BW-1:0]   w_cnt_nxt;
  logic [TW-1:0]   r_to;
  logic [TW-1:0]   w_to_inc;
  logic            w_cap;
  logic            w_commit;
  logic            w_tmo;
  logic [7:0]      r_sh [6];

  assign w_to_inc = r_to + 1'b1;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_cap     = 1'b0;
    w_commit  = 1'b0;
    w_tmo     = 1'b0;
    if (i_rx_dv) begin
      unique case (r_state)
        S_IDLE: begin
          if (i_rx_byte == TIM_ID) w_next = S_SUB;
        end
        S_SUB: begin
          if (i_rx_byte == TIM_SUBCODE) begin
            w_next    = S_SKIP;
            w_cnt_nxt = '0;
          end else if (i_rx_byte != TIM_ID) begin
            w_next = S_IDLE;
          end
        end
        S_SKIP: begin
          if (r_cnt == BW'(SKIP_BYTES - 1)) begin
            w_next    = S_CAP;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_CAP: begin
          w_cap = 1'b1;
          if (r_cnt == BW'(6)) begin
            w_commit  = 1'b1;
            w_next    = S_IDLE;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end else if (r_state != S_IDLE && w_to_inc == TW'(TIMEOUT_CLKS)) begin
      // a byte in the same cycle takes precedence over expiry
      w_tmo     = 1'b1;
      w_next    = S_IDLE;
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge i_clk_10 or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_to    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (i_rx_dv || r_state == S_IDLE || w_tmo) r_to <= '0;
      else                                       r_to <= w_to_inc;
    end
  end

  always_ff @(posedge i_clk_10 or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 6; i++) r_sh[i] <= '0;
      o_seconds     <= '0;
      o_minutes     <= '0;
      o_hour        <= '0;
      o_day         <= '0;
      o_month       <= '0;
      o_year        <= '0;
      o_time_valid  <= 1'b0;
      o_timeout_err <= 1'b0;
      o_pkt_count   <= '0;
    end else begin
      o_time_valid  <= w_commit;
      o_timeout_err <= w_tmo;
      if (w_cap && !w_commit) r_sh[r_cnt[2:0]] <= i_rx_byte;
      // all fields move together on the final year byte
      if (w_commit) begin
        o_seconds   <= r_sh[0];
        o_minutes   <= r_sh[1];
        o_hour      <= r_sh[2];
        o_day       <= r_sh[3];
        o_month     <= r_sh[4];
        o_year      <= {r_sh[5], i_rx_byte};
        o_pkt_count <= o_pkt_count + 1'b1;
      end
    end
  end

endmodule
